// File: rtl/vblank_update_scheduler.sv
// Frame-level sequencer: on each rising edge of vertical blank, runs the game-update
// tasks one at a time with a start/done handshake, per-task timeout and overrun flag.
module vblank_update_scheduler #(
  parameter int N_TASKS = 4,
  parameter int TIMEOUT = 1024,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vblnk,
  input  logic               enable,
  input  logic               clr_err,
  input  logic [N_TASKS-1:0] task_done,
  output logic [N_TASKS-1:0] task_start,
  output logic [IDX_W-1:0]   cur_task,
  output logic               update_active,
  output logic               frame_tick,
  output logic [15:0]        frame_cnt,
  output logic [N_TASKS-1:0] timeout_err,
  output logic               overrun
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TASKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_NEXT, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               vblnk_d;
  logic               tick_nxt;
  logic               cnt_inc;
  logic [N_TASKS-1:0] idx_onehot;
  logic [N_TASKS-1:0] to_set;
  logic               done_sel;
  logic               rise, fall, busy, ovr_set;

  assign rise    = vblnk & ~vblnk_d;
  assign fall    = ~vblnk & vblnk_d;
  assign busy    = (state != S_IDLE);
  assign ovr_set = (rise | fall) & busy;

  // Decode idx by comparison so a wide idx never indexes past N_TASKS.
  always_comb begin
    idx_onehot = '0;
    done_sel   = 1'b0;
    for (int i = 0; i < N_TASKS; i++) begin
      if (idx == IDX_W'(i)) begin
        idx_onehot[i] = 1'b1;
        done_sel      = task_done[i];
      end
    end
  end

  assign task_start    = (state == S_START) ? idx_onehot : '0;
  assign update_active = busy;
  assign cur_task      = busy ? idx : '0;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    timer_nxt = timer;
    tick_nxt  = 1'b0;
    cnt_inc   = 1'b0;
    to_set    = '0;
    case (state)
      S_IDLE: begin
        if (rise && enable) begin
          state_nxt = S_START;
          idx_nxt   = '0;
          tick_nxt  = 1'b1;
        end
      end
      S_START: begin
        timer_nxt = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (done_sel) begin
          state_nxt = S_NEXT;
        end else if (timer == TMR_LAST) begin
          to_set    = idx_onehot;
          state_nxt = S_NEXT;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_NEXT: begin
        if (idx == IDX_LAST) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = S_START;
        end
      end
      S_DONE: begin
        cnt_inc   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      timer       <= '0;
      vblnk_d     <= 1'b1;  // a vblnk already high at reset release is not an edge
      frame_tick  <= 1'b0;
      frame_cnt   <= '0;
      timeout_err <= '0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      timer       <= timer_nxt;
      vblnk_d     <= vblnk;
      frame_tick  <= tick_nxt;
      if (cnt_inc) frame_cnt <= frame_cnt + 16'd1;
      // A set in the same cycle as clr_err takes priority.
      timeout_err <= to_set | (timeout_err & {N_TASKS{~clr_err}});
      overrun     <= ovr_set | (overrun & ~clr_err);
    end
  end

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed bench for vblank_update_scheduler (N_TASKS=4, TIMEOUT=16) with
// hand-computed expectations checked by immediate assertions.
module tb_vblank_update_scheduler;

  localparam int NT    = 4;
  localparam int TMO   = 16;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             vblnk;
  logic             enable;
  logic             clr_err;
  logic [NT-1:0]    task_done;
  logic [NT-1:0]    task_start;
  logic [IDX_W-1:0] cur_task;
  logic             update_active;
  logic             frame_tick;
  logic [15:0]      frame_cnt;
  logic [NT-1:0]    timeout_err;
  logic             overrun;

  int errors = 0;
  int checks = 0;

  vblank_update_scheduler #(.N_TASKS(NT), .TIMEOUT(TMO), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .vblnk(vblnk), .enable(enable), .clr_err(clr_err),
    .task_done(task_done), .task_start(task_start), .cur_task(cur_task),
    .update_active(update_active), .frame_tick(frame_tick), .frame_cnt(frame_cnt),
    .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called in task k's START cycle; done arrives d cycles later; returns in NEXT.
  task automatic do_task(input int k, input int d);
    check($sformatf("start_%0d", k), 32'(task_start), 32'(1 << k));
    check($sformatf("cur_%0d", k), 32'(cur_task), k);
    tick();
    check($sformatf("wait_quiet_%0d", k), 32'({frame_tick, task_start}), 0);
    repeat (d - 1) tick();
    task_done = NT'(1 << k);
    tick();
    task_done = '0;
    check($sformatf("next_%0d", k), 32'({update_active, task_start}), 32'h10);
  endtask

  // Runs tasks first..NT-1 and checks frame_cnt lands exactly 3 cycles after the last done.
  task automatic finish_seq(input int first, input int d, input int exp_cnt);
    for (int k = first; k < NT; k++) begin
      do_task(k, d);
      tick();
    end
    check("done_active", 32'(update_active), 1);
    check("done_cnt_old", 32'(frame_cnt), 32'(16'(exp_cnt - 1)));
    tick();
    check("idle_cnt", 32'(frame_cnt), 32'(16'(exp_cnt)));
    check("idle_inactive", 32'({update_active, cur_task}), 0);
  endtask

  initial begin
    rst = 1'b1; vblnk = 1'b0; enable = 1'b1; clr_err = 1'b0; task_done = '0;
    repeat (3) tick();
    check("rst_outputs", 32'({task_start, cur_task, update_active, frame_tick}), 0);
    check("rst_regs", 32'({frame_cnt, timeout_err, overrun}), 0);
    rst = 1'b0;

    // 1: nominal frame, done 5 cycles after each start -> starts every 7 cycles.
    repeat (6) tick();
    vblnk = 1'b1;
    tick();
    check("t1_frame_tick", 32'(frame_tick), 1);
    check("t1_active", 32'(update_active), 1);
    finish_seq(0, 5, 1);
    check("t1_no_err", 32'({timeout_err, overrun}), 0);
    vblnk = 1'b0;
    tick();

    // 2: task 2 never completes and times out after 16 WAIT cycles.
    vblnk = 1'b1;
    tick();
    do_task(0, 2); tick();
    do_task(1, 2); tick();
    check("t2_start2", 32'(task_start), 32'h4);
    repeat (16) tick();
    check("t2_tmo_early", 32'({update_active, timeout_err}), 32'h10);
    tick();
    check("t2_tmo_set", 32'(timeout_err), 32'h4);
    check("t2_next_quiet", 32'(task_start), 0);
    tick();
    finish_seq(3, 2, 2);
    check("t2_tmo_sticky", 32'(timeout_err), 32'h4);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t2_tmo_clr", 32'(timeout_err), 0);
    vblnk = 1'b0;
    tick();

    // 3: blanking ends while task 1 is waiting.
    vblnk = 1'b1;
    tick();
    do_task(0, 2); tick();
    check("t3_start1", 32'(task_start), 32'h2);
    tick();
    vblnk = 1'b0;
    tick();
    check("t3_overrun", 32'({update_active, overrun}), 32'h3);
    task_done = 4'b0010;
    tick();
    task_done = '0;
    tick();
    finish_seq(2, 3, 3);
    check("t3_ovr_sticky", 32'(overrun), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t3_ovr_clr", 32'(overrun), 0);

    // 4: reset mid-sequence while vblnk stays high.
    vblnk = 1'b1;
    tick();
    check("t4_start0", 32'(task_start), 32'h1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_rst_outputs", 32'({task_start, cur_task, update_active, frame_tick}), 0);
    check("t4_rst_cnt", 32'(frame_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_held_high", 32'({update_active, frame_tick, task_start}), 0);
    end
    vblnk = 1'b0;
    tick();
    vblnk = 1'b1;
    tick();
    check("t4_restart_tick", 32'(frame_tick), 1);
    finish_seq(0, 1, 1);

    // 5: enable low at the rise, then enable dropped mid-sequence.
    vblnk = 1'b0;
    tick();
    enable = 1'b0;
    vblnk  = 1'b1;
    tick();
    check("t5_disabled", 32'({update_active, frame_tick, task_start}), 0);
    repeat (3) tick();
    check("t5_still_idle", 32'({update_active, frame_cnt}), 32'h1);
    vblnk  = 1'b0;
    enable = 1'b1;
    tick();
    vblnk = 1'b1;
    tick();
    check("t5_start0", 32'(task_start), 32'h1);
    tick();
    task_done = 4'b1110;
    tick();
    task_done = '0;
    tick();
    check("t5_other_done_ignored", 32'({update_active, task_start, cur_task}), 32'h80);
    task_done = 4'b0001;
    tick();
    task_done = '0;
    tick();
    enable = 1'b0;
    finish_seq(1, 2, 2);
    enable = 1'b1;
    vblnk  = 1'b0;
    tick();

    // 6: second rise while busy coinciding with clr_err.
    vblnk = 1'b1;
    tick();
    check("t6_tick", 32'(frame_tick), 1);
    tick();
    vblnk = 1'b0;
    tick();
    vblnk   = 1'b1;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t6_set_wins", 32'(overrun), 1);
    check("t6_no_restart", 32'({frame_tick, task_start}), 0);
    tick();
    check("t6_no_tick", 32'(frame_tick), 0);
    task_done = 4'b0001;
    tick();
    task_done = '0;
    tick();
    finish_seq(1, 2, 3);
    repeat (5) tick();
    check("t6_single_frame", 32'({update_active, frame_tick, frame_cnt}), 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
